mem_port_arbiter: RTL and testbench

//  Two-requester controller in front of the 1024x64 data memory (separate read/write address, rd/wr strobes).
//  Per cycle: grants at most one read and one write, with round-robin on same-type contention.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory port controller.
//   MEM_DEPTH      : number of 64-bit words in the data memory
//   DEF_DATA_W     : default data width of requests, responses and memory port
//   DEF_ADDR_W     : default word address width, derived from MEM_DEPTH
//   arb_state_t    : round-robin priority state (which requester wins the next contention)
package mem_ctrl_pkg;

  localparam int MEM_DEPTH  = 1024;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-bit priority state.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (state -> PRI0, grants forced 0)
//   req   : request vector, [0] = requester 0, [1] = requester 1
//   en    : 1 = rotate priority after a contended grant, 0 = requester 0 always wins
//   gnt   : one-hot (or zero) grant vector, combinational from req and state
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       contend;

  assign contend = req[0] & req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRI0;
    end else begin
      state <= state_nxt;
    end
  end

  // Only a contended grant moves priority; the winner drops to the back.
  always_comb begin
    state_nxt = state;
    if (en && contend) begin
      state_nxt = (state == PRI0) ? PRI1 : PRI0;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (contend) begin
        gnt = (state == PRI0) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester controller in front of the 1024x64 data memory.
// Grants at most one read and one write per cycle (round-robin within each
// type), forwards write data to a same-address read in the same cycle, and
// returns read data one cycle after the grant on a per-requester channel.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   req_valid/we   : per-requester request valid and direction (1 = write)
//   req_adr/wdata  : packed per-requester address and write data (req0 in low bits)
//   req_ready      : per-requester grant; transfer on valid && ready
//   rsp_valid      : one-cycle pulse, read data valid for that requester
//   rsp_rdata      : packed per-requester read data, held until the next response
//   mem_*          : drive of the memory's read/write ports; mem_data_out is its
//                    combinational read data
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_adr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0]   mem_data_in,
  output logic [ADDR_W-1:0]   mem_read_adr,
  output logic [ADDR_W-1:0]   mem_write_adr,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic [DATA_W-1:0]   mem_data_out
);

  logic [1:0]          rd_req, wr_req;
  logic [1:0]          rd_gnt, wr_gnt;
  logic                rd_any, wr_any;
  logic [ADDR_W-1:0]   rd_adr, wr_adr;
  logic [DATA_W-1:0]   wr_data;
  logic                collision;
  logic [DATA_W-1:0]   rd_data_p0;
  logic [1:0]          vld_p1;
  logic [2*DATA_W-1:0] rdata_p1;

  // ---- p0: arbitration, collision detect and memory drive ----
  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid &  req_we;

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .en    (RR_EN),
    .gnt   (rd_gnt)
  );

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .en    (RR_EN),
    .gnt   (wr_gnt)
  );

  assign req_ready = rd_gnt | wr_gnt;
  assign rd_any    = |rd_gnt;
  assign wr_any    = |wr_gnt;
  assign rd_adr    = rd_gnt[1] ? req_adr[2*ADDR_W-1:ADDR_W]   : req_adr[ADDR_W-1:0];
  assign wr_adr    = wr_gnt[1] ? req_adr[2*ADDR_W-1:ADDR_W]   : req_adr[ADDR_W-1:0];
  assign wr_data   = wr_gnt[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign collision = rd_any & wr_any & (rd_adr == wr_adr);

  // On a collision the memory read is suppressed (its output would be
  // undefined) and the read is served from the write data instead.
  always_comb begin
    mem_rd        = rd_any & ~collision;
    mem_read_adr  = rd_any ? rd_adr : '0;
    mem_wr        = wr_any;
    mem_write_adr = wr_any ? wr_adr  : '0;
    mem_data_in   = wr_any ? wr_data : '0;
  end

  assign rd_data_p0 = collision ? wr_data : mem_data_out;

  // ---- p1: read response registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 2'b00;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_gnt;
      if (rd_gnt[0]) rdata_p1[DATA_W-1:0]        <= rd_data_p0;
      if (rd_gnt[1]) rdata_p1[2*DATA_W-1:DATA_W] <= rd_data_p0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam logic [DW-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic          clk = 1'b0;
  logic          rst_n;

  // main instance (round-robin)
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_adr;
  logic [2*DW-1:0] req_wdata, rsp_rdata;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic [AW-1:0] mem_read_adr, mem_write_adr;
  logic          mem_rd, mem_wr;

  // fixed-priority instance
  logic [1:0]    b_valid, b_ready, b_we, b_rsp_valid;
  logic [2*AW-1:0] b_adr;
  logic [2*DW-1:0] b_wdata, b_rsp_rdata;
  logic [DW-1:0] b_mem_data_in, b_mem_data_out;
  logic [AW-1:0] b_mem_read_adr, b_mem_write_adr;
  logic          b_mem_rd, b_mem_wr;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_data_in(mem_data_in), .mem_read_adr(mem_read_adr),
    .mem_write_adr(mem_write_adr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RR_EN(1'b0)) u_dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_adr(b_adr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_data_in(b_mem_data_in), .mem_read_adr(b_mem_read_adr),
    .mem_write_adr(b_mem_write_adr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_data_out(b_mem_data_out)
  );

  always #5 clk = ~clk;

  // environment memories
  logic [DW-1:0] mem    [1024];
  logic [DW-1:0] shadow [1024];   // reference model's view of memory contents

  function automatic logic [DW-1:0] init_val(input int a);
    return {32'h1000_0000 + 32'(a), ~32'(a)};
  endfunction

  function automatic logic [DW-1:0] fix_pat(input logic [AW-1:0] a);
    return {32'hC0DE_0000, 22'd0, a};
  endfunction

  assign mem_data_out   = mem_rd   ? mem[mem_read_adr] : GARBAGE;
  assign b_mem_data_out = b_mem_rd ? fix_pat(b_mem_read_adr) : GARBAGE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int epoch  = 0;

  typedef struct packed {
    int            due;
    int            ep;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sbq [2][$];

  bit pri_rd, pri_wr;   // requester that wins the next contention of that type

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] adr_of(input int i);
    return req_adr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wd_of(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] r, input bit p);
    if (r == 2'b11) return p ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_adr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // tracker variables
  logic [1:0]    t_rdq, t_wrq, t_er, t_ew;
  int            t_ri, t_wi;
  logic [AW-1:0] t_radr, t_wadr;
  logic [DW-1:0] t_wdat;
  bit            t_coll;
  exp_t          t_e;
  // monitor variables
  exp_t          m_e;
  logic [DW-1:0] m_last [2];
  int            m_epoch = 0;
  logic [1:0]    acc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem[a]    = init_val(a);
      shadow[a] = init_val(a);
    end
    pri_rd = 1'b0; pri_wr = 1'b0;
    m_last[0] = '0; m_last[1] = '0;
    rst_n = 1'b0;
    set_req(0, 1, 0, 10'd1, 64'd0);
    set_req(1, 1, 1, 10'd2, 64'h55);
    b_valid = 2'b11; b_we = 2'b00; b_adr = '0; b_wdata = '0;

    fork
      // memory write port
      forever begin
        @(posedge clk);
        if (mem_wr) mem[mem_write_adr] = mem_data_in;
      end
      // request tracker: predicts grants and memory drive, pushes expected responses
      forever begin
        @(negedge clk);
        if (rst_n) begin
          t_rdq = req_valid & ~req_we;
          t_wrq = req_valid &  req_we;
          t_er  = pick(t_rdq, pri_rd);
          t_ew  = pick(t_wrq, pri_wr);
          t_ri  = t_er[1] ? 1 : 0;
          t_wi  = t_ew[1] ? 1 : 0;
          t_radr = (t_er != 0) ? adr_of(t_ri) : '0;
          t_wadr = (t_ew != 0) ? adr_of(t_wi) : '0;
          t_wdat = (t_ew != 0) ? wd_of(t_wi)  : '0;
          t_coll = (t_er != 0) && (t_ew != 0) && (t_radr == t_wadr);
          chk(req_ready == (t_er | t_ew), "req_ready", 64'(req_ready), 64'(t_er | t_ew));
          chk(mem_rd == ((t_er != 0) && !t_coll), "mem_rd", 64'(mem_rd), 64'((t_er != 0) && !t_coll));
          chk(mem_wr == (t_ew != 0), "mem_wr", 64'(mem_wr), 64'(t_ew != 0));
          chk(mem_read_adr == t_radr, "mem_read_adr", 64'(mem_read_adr), 64'(t_radr));
          chk(mem_write_adr == t_wadr, "mem_write_adr", 64'(mem_write_adr), 64'(t_wadr));
          chk(mem_data_in == t_wdat, "mem_data_in", mem_data_in, t_wdat);
          if (t_er != 0) begin
            t_e.due = cyc + 1;
            t_e.ep  = epoch;
            t_e.d   = t_coll ? t_wdat : shadow[t_radr];
            sbq[t_ri].push_back(t_e);
          end
          if (t_ew != 0) shadow[t_wadr] = t_wdat;
          if (t_rdq == 2'b11) pri_rd = (t_ri == 0);
          if (t_wrq == 2'b11) pri_wr = (t_wi == 0);
        end
      end
      // response monitor: pops the scoreboard whenever a response appears
      forever begin
        @(posedge clk); #2;
        if (m_epoch != epoch) begin
          m_epoch = epoch;
          m_last[0] = '0; m_last[1] = '0;
        end
        for (int i = 0; i < 2; i++) begin
          while (sbq[i].size() > 0 && sbq[i][0].ep != epoch) void'(sbq[i].pop_front());
          if (rsp_valid[i]) begin
            if (sbq[i].size() == 0 || sbq[i][0].due != cyc) begin
              chk(1'b0, $sformatf("unexpected_rsp%0d", i), rsp_rdata[i*DW +: DW], 64'd0);
            end else begin
              m_e = sbq[i].pop_front();
              chk(rsp_rdata[i*DW +: DW] == m_e.d, $sformatf("rsp_rdata%0d", i), rsp_rdata[i*DW +: DW], m_e.d);
            end
            m_last[i] = rsp_rdata[i*DW +: DW];
          end else begin
            if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
              m_e = sbq[i].pop_front();
              chk(1'b0, $sformatf("missing_rsp%0d", i), 64'd0, m_e.d);
            end
            chk(rsp_rdata[i*DW +: DW] == m_last[i], $sformatf("rdata_hold%0d", i), rsp_rdata[i*DW +: DW], m_last[i]);
          end
        end
      end
    join_none

    // reset state while requests are presented
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(req_ready == 2'b00, "rst_req_ready", 64'(req_ready), 64'd0);
    chk({mem_rd, mem_wr} == 2'b00, "rst_mem_strobes", 64'({mem_rd, mem_wr}), 64'd0);
    chk(rsp_valid == 2'b00, "rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk(rsp_rdata == '0, "rst_rsp_rdata", rsp_rdata[DW-1:0], 64'd0);
    chk(b_ready == 2'b00, "rst_fix_ready", 64'(b_ready), 64'd0);
    idle();
    b_valid = 2'b00;
    @(negedge clk); #1 rst_n = 1'b1;

    // write then read back the same address
    step();
    set_req(0, 1, 1, 10'd5, 64'hDEAD);
    step();
    set_req(0, 1, 0, 10'd5, 64'd0);
    step();
    idle();
    @(negedge clk);
    chk(rsp_valid == 2'b01, "wr_rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk(rsp_rdata[DW-1:0] == 64'hDEAD, "wr_rd_data", rsp_rdata[DW-1:0], 64'hDEAD);

    // same-cycle write/read collision
    step();
    set_req(0, 1, 1, 10'd7, 64'h1234);
    set_req(1, 1, 0, 10'd7, 64'd0);
    @(negedge clk);
    chk(req_ready == 2'b11, "coll_ready", 64'(req_ready), 64'd3);
    chk(mem_rd == 1'b0, "coll_mem_rd", 64'(mem_rd), 64'd0);
    step();
    idle();
    @(negedge clk);
    chk(rsp_valid == 2'b10, "coll_rsp_valid", 64'(rsp_valid), 64'd2);
    chk(rsp_rdata[2*DW-1:DW] == 64'h1234, "coll_data", rsp_rdata[2*DW-1:DW], 64'h1234);

    // continuous read contention alternates
    step();
    set_req(0, 1, 0, 10'd1, 64'd0);
    set_req(1, 1, 0, 10'd2, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(req_ready == ((k % 2 == 0) ? 2'b01 : 2'b10), "rr_alternate", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      step();
    end
    idle();

    // both write the same address: winner first, loser's data is final
    step();
    set_req(0, 1, 1, 10'd3, 64'hAAAA_0000);
    set_req(1, 1, 1, 10'd3, 64'hBBBB_1111);
    @(negedge clk);
    chk(req_ready == 2'b01, "ww_first", 64'(req_ready), 64'd1);
    step();
    set_req(0, 0, 0, 10'd0, 64'd0);
    @(negedge clk);
    chk(req_ready == 2'b10, "ww_second", 64'(req_ready), 64'd2);
    step();
    idle();
    step();
    set_req(0, 1, 0, 10'd3, 64'd0);
    step();
    idle();
    @(negedge clk);
    chk(rsp_rdata[DW-1:0] == 64'hBBBB_1111, "ww_final_data", rsp_rdata[DW-1:0], 64'hBBBB_1111);

    // reset in the middle of a read: its response is dropped
    step();
    set_req(0, 1, 0, 10'd9, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    epoch++;
    pri_rd = 1'b0; pri_wr = 1'b0;
    #1;
    chk(rsp_valid == 2'b00, "midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk(rsp_rdata == '0, "midrst_rsp_rdata", rsp_rdata[DW-1:0], 64'd0);
    chk({mem_rd, mem_wr, req_ready} == 4'd0, "midrst_comb_out", 64'({mem_rd, mem_wr, req_ready}), 64'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(rsp_valid == 2'b00, "midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end

    // randomized traffic; a stalled request is held until accepted
    step();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !acc[i])) begin
          set_req(i, ($urandom_range(3) != 0), $urandom_range(1), AW'($urandom_range(15)), {$urandom, $urandom});
        end
      end
    end
    idle();
    repeat (3) step();
    chk(sbq[0].size() == 0, "drain_q0", 64'(sbq[0].size()), 64'd0);
    chk(sbq[1].size() == 0, "drain_q1", 64'(sbq[1].size()), 64'd0);

    // fixed priority: requester 0 always wins read contention
    b_valid = 2'b11; b_we = 2'b00;
    b_adr = {10'd6, 10'd4};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) chk(b_ready == 2'b01, "fix_ready", 64'(b_ready), 64'd1);
      if (k >= 1) begin
        chk(b_rsp_valid == 2'b01, "fix_rsp_valid", 64'(b_rsp_valid), 64'd1);
        chk(b_rsp_rdata[DW-1:0] == fix_pat(10'd4), "fix_rsp_data", b_rsp_rdata[DW-1:0], fix_pat(10'd4));
      end
      step();
      if (k == 2) b_valid = 2'b00;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
